// File: rtl/exec_mem_pipe_pkg.sv
// Shared execute-stage types.
//   execute_data_t : per-lane execute payload handed to the memory stage
//   lane_mask_t    : one bit per issue lane, lane 0 oldest
//   exec_bundle_t  : one issue bundle (lane valids, lane exceptions, payloads)
package exec_mem_pipe_pkg;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
  } execute_data_t;

  localparam int unsigned DefaultLanes = 2;
  localparam int unsigned ExecDataW    = $bits(execute_data_t);

  typedef logic [DefaultLanes-1:0] lane_mask_t;

  typedef struct {
    lane_mask_t    valid;
    lane_mask_t    exc;
    execute_data_t data [DefaultLanes];
  } exec_bundle_t;

endpackage

// File: rtl/exec_lane_squash.sv
// In-bundle exception squash. The oldest lane that is both valid and
// excepting keeps its flags; every younger lane is dropped (valid=0, exc=0).
// Lanes older than or equal to that lane pass through unchanged.
//   in_valid, in_exc : incoming per-lane valid / exception flags
//   sq_valid, sq_exc : flags to store after squashing younger lanes
module exec_lane_squash #(
  parameter int unsigned LANES = 2
) (
  input  logic [LANES-1:0] in_valid,
  input  logic [LANES-1:0] in_exc,
  output logic [LANES-1:0] sq_valid,
  output logic [LANES-1:0] sq_exc
);

  always_comb begin
    logic seen;
    seen     = 1'b0;
    sq_valid = '0;
    sq_exc   = '0;
    for (int i = 0; i < LANES; i++) begin
      sq_valid[i] = in_valid[i] & ~seen;
      sq_exc[i]   = in_exc[i] & ~seen;
      // Everything younger than the first excepting lane is squashed.
      seen        = seen | (in_valid[i] & in_exc[i]);
    end
  end

endmodule

// File: rtl/exec_mem_pipe.sv
// Execute -> memory stage bundle buffer (circular, DEPTH entries of LANES lanes).
//   clk, resetn          : clock, asynchronous active-low reset
//   in_valid/exc/data    : incoming bundle (lane i payload at [i*DATA_W +: DATA_W])
//   in_ready             : buffer not full; depends on stored state only
//   out_valid/exc/data   : head bundle, zero when empty
//   out_ready            : memory stage consumes the head bundle
//   flush                : discard all stored bundles and same-cycle push/pop
//   count                : occupied entries
module exec_mem_pipe
  import exec_mem_pipe_pkg::*;
#(
  parameter int unsigned LANES  = DefaultLanes,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = $bits(execute_data_t)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [LANES-1:0]          in_valid,
  input  logic [LANES-1:0]          in_exc,
  input  logic [LANES*DATA_W-1:0]   in_data,
  output logic                      in_ready,
  output logic [LANES-1:0]          out_valid,
  output logic [LANES-1:0]          out_exc,
  output logic [LANES*DATA_W-1:0]   out_data,
  input  logic                      out_ready,
  input  logic                      flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [LANES-1:0]        sq_valid, sq_exc;
  logic [LANES-1:0]        valid_q [DEPTH];
  logic [LANES-1:0]        exc_q   [DEPTH];
  logic [LANES*DATA_W-1:0] data_q  [DEPTH];
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]         count_q, count_d;
  logic                    empty, push, pop;

  exec_lane_squash #(
    .LANES (LANES)
  ) u_squash (
    .in_valid (in_valid),
    .in_exc   (in_exc),
    .sq_valid (sq_valid),
    .sq_exc   (sq_exc)
  );

  // Explicit compare keeps wrap correct for non-power-of-two depths.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count_q == '0);
  assign in_ready  = (count_q < DepthCnt);
  assign push      = in_ready & (|in_valid) & ~flush;
  assign out_valid = empty ? '0 : valid_q[rd_ptr_q];
  assign out_exc   = empty ? '0 : exc_q[rd_ptr_q];
  assign out_data  = empty ? '0 : data_q[rd_ptr_q];
  assign pop       = out_valid[0] & out_ready & ~flush;
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= '0;
        exc_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          valid_q[i] <= '0;
          exc_q[i]   <= '0;
        end
      end else begin
        // Push and pop never target the same entry: a pop needs count>0 and
        // a push needs count<DEPTH, so write and read pointers differ.
        if (pop) begin
          valid_q[rd_ptr_q] <= '0;
          exc_q[rd_ptr_q]   <= '0;
        end
        if (push) begin
          valid_q[wr_ptr_q] <= sq_valid;
          exc_q[wr_ptr_q]   <= sq_exc;
          data_q[wr_ptr_q]  <= in_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_exec_mem_pipe.sv
// Directed bench for exec_mem_pipe: a DEPTH=2 instance for handshake, squash,
// flush and reset cases, and a DEPTH=3 instance for pointer wrap streaming.
module tb_exec_mem_pipe;
  import exec_mem_pipe_pkg::*;

  localparam int unsigned DW = $bits(execute_data_t);
  localparam int unsigned BW = 2 * DW;

  logic          clk = 1'b0;
  logic          resetn;
  logic [1:0]    a_in_valid, a_in_exc, a_out_valid, a_out_exc;
  logic [BW-1:0] a_in_data, a_out_data;
  logic          a_in_ready, a_out_ready, a_flush;
  logic [1:0]    a_count;
  logic [1:0]    b_in_valid, b_in_exc, b_out_valid, b_out_exc;
  logic [BW-1:0] b_in_data, b_out_data;
  logic          b_in_ready, b_out_ready, b_flush;
  logic [1:0]    b_count;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] da, db, dc, dd, de, df;

  always #5 clk = ~clk;

  exec_mem_pipe #(.LANES(2), .DEPTH(2)) u_dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (a_in_valid),
    .in_exc    (a_in_exc),
    .in_data   (a_in_data),
    .in_ready  (a_in_ready),
    .out_valid (a_out_valid),
    .out_exc   (a_out_exc),
    .out_data  (a_out_data),
    .out_ready (a_out_ready),
    .flush     (a_flush),
    .count     (a_count)
  );

  exec_mem_pipe #(.LANES(2), .DEPTH(3)) u_dut3 (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (b_in_valid),
    .in_exc    (b_in_exc),
    .in_data   (b_in_data),
    .in_ready  (b_in_ready),
    .out_valid (b_out_valid),
    .out_exc   (b_out_exc),
    .out_data  (b_out_data),
    .out_ready (b_out_ready),
    .flush     (b_flush),
    .count     (b_count)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] bun(input logic [DW-1:0] l0, input logic [DW-1:0] l1);
    return {l1, l0};
  endfunction

  task automatic a_drive(input logic [1:0] v, input logic [1:0] e, input logic [BW-1:0] d);
    a_in_valid = v;
    a_in_exc   = e;
    a_in_data  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] q [$];
    int sent;
    int cyc;
    logic do_pop, do_push;

    da = 37'h0AAAA0001; db = 37'h0BBBB0002; dc = 37'h0CCCC0003;
    dd = 37'h0DDDD0004; de = 37'h0EEEE0005; df = 37'h0FFFF0006;
    resetn = 1'b0;
    a_drive(2'b00, 2'b00, '0);
    a_out_ready = 1'b0; a_flush = 1'b0;
    b_in_valid = '0; b_in_exc = '0; b_in_data = '0; b_out_ready = 1'b0; b_flush = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_count", 128'(a_count), 128'(0));
    check("rst_out_valid", 128'(a_out_valid), 128'(0));
    check("rst_out_exc", 128'(a_out_exc), 128'(0));
    check("rst_out_data", 128'(a_out_data), 128'(0));
    check("rst_in_ready", 128'(a_in_ready), 128'(1));
    resetn = 1'b1;
    tick();

    // First push, no bypass, visible next cycle
    a_drive(2'b11, 2'b00, bun(da, db));
    #1;
    check("nobypass_valid", 128'(a_out_valid), 128'(0));
    tick();
    check("p1_valid", 128'(a_out_valid), 128'(2'b11));
    check("p1_data", 128'(a_out_data), 128'(bun(da, db)));
    check("p1_count", 128'(a_count), 128'(1));
    a_drive(2'b11, 2'b00, bun(dc, dd));
    tick();
    check("p2_count", 128'(a_count), 128'(2));
    check("full_in_ready", 128'(a_in_ready), 128'(0));
    a_drive(2'b11, 2'b00, bun(de, df));
    tick();
    check("p3_held_count", 128'(a_count), 128'(2));
    check("p3_head", 128'(a_out_data), 128'(bun(da, db)));
    // Full buffer: pop only, the held bundle waits
    a_out_ready = 1'b1;
    tick();
    check("pop1_count", 128'(a_count), 128'(1));
    check("pop1_head", 128'(a_out_data), 128'(bun(dc, dd)));
    tick();
    check("pushpop_count", 128'(a_count), 128'(1));
    check("pushpop_head", 128'(a_out_data), 128'(bun(de, df)));
    a_drive(2'b00, 2'b00, '0);
    tick();
    check("drain_count", 128'(a_count), 128'(0));
    check("drain_valid", 128'(a_out_valid), 128'(0));
    tick();
    check("empty_no_underflow", 128'(a_count), 128'(0));
    check("empty_in_ready", 128'(a_in_ready), 128'(1));

    // Squash: lane 0 excepts, lane 1 dropped
    a_out_ready = 1'b0;
    a_drive(2'b11, 2'b01, bun(da, db));
    tick();
    a_drive(2'b00, 2'b00, '0);
    check("sq0_valid", 128'(a_out_valid), 128'(2'b01));
    check("sq0_exc", 128'(a_out_exc), 128'(2'b01));
    check("sq0_data", 128'(a_out_data[DW-1:0]), 128'(da));
    // Lane 1 excepts: nothing younger, both kept
    a_out_ready = 1'b1;
    a_drive(2'b11, 2'b10, bun(dc, dd));
    tick();
    a_drive(2'b00, 2'b00, '0);
    a_out_ready = 1'b0;
    check("sq1_valid", 128'(a_out_valid), 128'(2'b11));
    check("sq1_exc", 128'(a_out_exc), 128'(2'b10));
    check("sq1_data", 128'(a_out_data), 128'(bun(dc, dd)));
    check("sq1_count", 128'(a_count), 128'(1));
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    check("sq_drain", 128'(a_count), 128'(0));

    // Flush while full with push and pop requested
    a_drive(2'b01, 2'b00, bun(da, '0));
    tick();
    a_drive(2'b01, 2'b00, bun(db, '0));
    tick();
    check("fl_pre_count", 128'(a_count), 128'(2));
    a_drive(2'b01, 2'b00, bun(de, '0));
    a_out_ready = 1'b1;
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    a_out_ready = 1'b0;
    a_drive(2'b00, 2'b00, '0);
    check("fl_count", 128'(a_count), 128'(0));
    check("fl_valid", 128'(a_out_valid), 128'(0));
    // Flush with one entry and a push that would otherwise be accepted
    a_drive(2'b01, 2'b00, bun(dc, '0));
    tick();
    a_drive(2'b01, 2'b00, bun(dd, '0));
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    a_drive(2'b01, 2'b00, bun(df, '0));
    check("fl_push_drop", 128'(a_count), 128'(0));
    tick();
    a_drive(2'b00, 2'b00, '0);
    check("post_fl_count", 128'(a_count), 128'(1));
    check("post_fl_data", 128'(a_out_data[DW-1:0]), 128'(df));

    // Asynchronous reset mid-operation
    a_drive(2'b01, 2'b00, bun(de, '0));
    tick();
    a_drive(2'b00, 2'b00, '0);
    check("ar_pre_count", 128'(a_count), 128'(2));
    #2;
    resetn = 1'b0;
    #1;
    check("ar_count", 128'(a_count), 128'(0));
    check("ar_valid", 128'(a_out_valid), 128'(0));
    #1;
    resetn = 1'b1;
    a_drive(2'b01, 2'b00, bun(db, '0));
    tick();
    a_drive(2'b00, 2'b00, '0);
    check("ar_push_count", 128'(a_count), 128'(1));
    check("ar_push_data", 128'(a_out_data[DW-1:0]), 128'(db));

    // DEPTH=3 streaming with out_ready pattern 1,0,1 against a queue model
    sent = 0;
    cyc  = 0;
    while ((sent < 10 || q.size() > 0) && cyc < 200) begin
      b_in_valid  = (sent < 10) ? 2'b01 : 2'b00;
      b_in_data   = {DW'(0), DW'(sent + 100)};
      b_out_ready = ((cyc % 3) != 1);
      #1;
      check("b_count", 128'(b_count), 128'(q.size()));
      check("b_in_ready", 128'(b_in_ready), 128'(q.size() < 3));
      if (q.size() > 0) begin
        check("b_head_valid", 128'(b_out_valid), 128'(2'b01));
        check("b_head_data", 128'(b_out_data[DW-1:0]), 128'(q[0]));
      end
      do_pop  = b_out_ready && (q.size() > 0);
      do_push = b_in_valid[0] && (q.size() < 3);
      tick();
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(DW'(sent + 100));
        sent++;
      end
      cyc++;
    end
    b_in_valid  = '0;
    b_out_ready = 1'b0;
    check("b_done", 128'(q.size() == 0 && sent == 10), 128'(1));
    #1;
    check("b_final_count", 128'(b_count), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exec_mem_pipe.md
Name: exec_mem_pipe

Overview:
- Parametrised execute→memory stage buffer; successor to the single-register execute payload latch.
- Holds up to DEPTH issue bundles, each LANES wide, carrying the execute payload per lane.
- valid/ready handshake on both sides, pipeline flush, and in-bundle exception squash of younger lanes.
- Sits between the execute stage and the memory stage; the memory stage drives out_ready from dcache stall.

Parameters:
- LANES, 2, issue lanes per bundle (≥1); lane 0 is oldest.
- DEPTH, 2, bundle entries (≥1; need not be a power of two).
- DATA_W, $bits(execute_data_t), payload bits per lane.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- in_valid  in  LANES  per-lane valid of the incoming bundle, contiguous from lane 0
- in_exc  in  LANES  per-lane "exception raised in execute"
- in_data  in  LANES*DATA_W  payload; lane i at [i*DATA_W +: DATA_W]
- in_ready  out  1  bundle accepted this cycle when in_ready & |in_valid
- out_valid  out  LANES  head bundle lane valids
- out_exc  out  LANES  head bundle lane exception flags
- out_data  out  LANES*DATA_W  head bundle payload
- out_ready  in  1  memory stage consumes the head bundle
- flush  in  1  synchronous pipeline flush (exception commit or branch redirect)
- count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (resetn low, asynchronous): count=0; read/write pointers=0; all stored valid/exc/data=0; out_valid=0, out_exc=0, out_data=0, in_ready=1.
- Storage: circular buffer of DEPTH entries, each entry = {lane valid mask, lane exc mask, lane data}.
- in_ready = (count < DEPTH). It is registered-state only and has no combinational path from out_ready. A full buffer does not accept a push even when a pop happens in the same cycle.
- push = in_ready & |in_valid & ~flush. An all-invalid bundle is never stored.
- Squash on push: let k = lowest lane with in_valid[k] & in_exc[k].
  - Lanes j > k are stored with valid=0 and exc=0.
  - Lane k and older lanes are stored unchanged.
  - Payload bits of squashed lanes are don't-care; the bench checks only valid lanes.
- pop = out_valid[0] & out_ready & ~flush.
- out_* reflect the head entry combinationally from storage. When count=0, out_valid=0 and out_exc=0.
- Latency: a bundle pushed in cycle N is visible at the output in cycle N+1 at the earliest. There is no same-cycle bypass.
- Pointer wrap: increment modulo DEPTH, with an explicit compare to DEPTH-1 (non-power-of-two safe).
- count update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- flush: next cycle count=0, pointers=0, all stored valid/exc cleared. A push and a pop in the same cycle as flush are both discarded. Flush dominates every other event.
- Empty with out_ready=1: no pop, count stays 0, no underflow.
- resetn asserted mid-operation clears all state immediately; the first push after release is accepted normally.

Decomposition:
- Add to the shared execute package:
  - lane_mask_t (LANES-bit);
  - exec_bundle_t {lane_mask_t valid, exc; execute_data_t data[LANES]};
  - a localparam for the default LANES.
- One sub-module, exec_lane_squash: combinational priority mask that produces the stored valid/exc from in_valid/in_exc. Shared later by the issue stage.
- Buffer control (pointers, count, flush) stays in exec_mem_pipe.

Test Plan:
- Reset, then push bundle valid=2'b11, exc=2'b00, data={B,A}, with out_ready=0 → cycle+1: out_valid=2'b11, out_data={B,A}, count=1.
- LANES=2, DEPTH=2: push 3 bundles back-to-back with out_ready=0 → first two accepted; in_ready=0 from count=2; third held. Raise out_ready → order preserved A, B, C; count returns to 0.
- Push valid=2'b11, exc=2'b01 → stored out_valid=2'b01, out_exc=2'b01. Push valid=2'b11, exc=2'b10 → out_valid=2'b11, out_exc=2'b10.
- count=2, assert flush with in_valid=2'b01 and out_ready=1 → next cycle count=0, out_valid=0, nothing was popped or pushed.
- DEPTH=3: continuous push and pop for 10 bundles with out_ready toggling 1,0,1 → pointers wrap through index 2→0, no loss or duplication, count never exceeds 3.
- Pulse resetn low asynchronously with count=2 → out_valid=0 and count=0 before the next clk edge.
